// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, single carry flop; three-state FSM.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE and ignored (not queued) while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_s    = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_c    = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
  assign w_last = (r_cnt == LAST_BIT);

  // The bit being inserted is part of the result on the final edge.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_nxt = w_s;
    end else begin : g_res_wn
      assign w_res_nxt = {w_s, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_carry <= w_c;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_res   <= w_res_nxt;
          // Ends at WIDTH, which always fits in CW bits.
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_res_nxt;
            r_cout <= w_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector and random bench for serial_adder at WIDTH 1, 8 and 32.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start1 = 1'b0, cin1 = 1'b0;
  logic [0:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1;
  logic [0:0]  sum1;

  logic        start32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, cout32;
  logic [31:0] sum32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );
  serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // done must never be high on two consecutive cycles
  logic [2:0] prev_done = '0;
  always @(negedge clk) begin
    if (done8)  chk("done8_single",  {63'b0, prev_done[0]}, 64'd0);
    if (done1)  chk("done1_single",  {63'b0, prev_done[1]}, 64'd0);
    if (done32) chk("done32_single", {63'b0, prev_done[2]}, 64'd0);
    prev_done <= {done32, done1, done8};
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  // One WIDTH=8 operation; lat = negedges after the accept edge until done.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output int lat, output int busy_cnt);
    @(posedge clk); #1;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; busy_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
    if (busy8) busy_cnt++;
  endtask

  task automatic set_in(input int w, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts);
    case (w)
      1:       begin a1 = ta[0:0]; b1 = tb[0:0]; cin1 = tc; start1 = ts; end
      8:       begin a8 = ta[7:0]; b8 = tb[7:0]; cin8 = tc; start8 = ts; end
      default: begin a32 = ta; b32 = tb; cin32 = tc; start32 = ts; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic logic [32:0] get_res(input int w);
    case (w)
      1:       return {31'b0, cout1, sum1};
      8:       return {24'b0, cout8, sum8};
      default: return {cout32, sum32};
    endcase
  endfunction

  task automatic run_rand(input int w, input int n_ops);
    logic [31:0] m, ra, rb;
    logic        rc;
    logic [32:0] full, exp_res;
    int          lat;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < n_ops; i++) begin
      if (i == 0) begin
        ra = '1; rb = '1; rc = 1'b1;
      end else begin
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      end
      ra = ra & m; rb = rb & m;
      full = 33'(ra) + 33'(rb) + 33'(rc);
      exp_res = '0;
      exp_res[31:0] = full[31:0] & m;
      exp_res[w] = full[w];
      @(posedge clk); #1;
      set_in(w, ra, rb, rc, 1'b1);
      @(posedge clk); #1;
      set_in(w, '1, '1, 1'b1, 1'b0);
      lat = -1;
      for (int n = 0; n < w + 10; n++) begin
        @(negedge clk);
        if (get_done(w)) begin
          lat = n;
          break;
        end
      end
      chk($sformatf("rand_w%0d_lat", w), 64'(lat), 64'(w));
      chk($sformatf("rand_w%0d_res a=%0h b=%0h c=%0d", w, ra, rb, rc),
          64'(get_res(w)), 64'(exp_res));
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int lat, bcnt, done_seen, t, nd;
    int tdone[3];

    vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    // reset state
    #22;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum",  64'(sum8),  64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      chk($sformatf("vec%0d_lat", i),  64'(lat),   64'd8);
      chk($sformatf("vec%0d_busy", i), 64'(bcnt),  64'd9);
      chk($sformatf("vec%0d_sum", i),  64'(sum8),  64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_cout", i), 64'(cout8), 64'(vecs[i].exp_cout));
    end

    // start during RUN is ignored; operand changes after capture have no effect
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1; bcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (n == 2) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
      if (n == 3) start8 = 1'b0;
      if (n == 4) chk("ign_sum_hold", 64'(sum8), 64'h46);
      if (done8) begin lat = n; break; end
    end
    chk("ign_lat",  64'(lat),   64'd8);
    chk("ign_busy", 64'(bcnt),  64'd9);
    chk("ign_sum",  64'(sum8),  64'h30);
    chk("ign_cout", 64'(cout8), 64'd0);
    @(negedge clk); @(negedge clk);
    chk("ign_no_queue", 64'(busy8), 64'd0);

    // reset mid-RUN aborts immediately
    @(posedge clk); #1;
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int n = 0; n < 4; n++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum",  64'(sum8),  64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run8(8'h3C, 8'h0F, 1'b0, lat, bcnt);
    chk("post_rst_lat", 64'(lat),   64'd8);
    chk("post_rst_sum", 64'(sum8),  64'h4B);
    chk("post_rst_cout", 64'(cout8), 64'd0);

    // start held high: back-to-back every WIDTH+2 cycles
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    nd = 0; t = 0;
    while (nd < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done8) begin
        tdone[nd] = t;
        chk($sformatf("b2b_sum%0d", nd), 64'(sum8), 64'h02);
        nd++;
      end
    end
    start8 = 1'b0;
    chk("b2b_pulses", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("b2b_gap0", 64'(tdone[1] - tdone[0]), 64'd10);
      chk("b2b_gap1", 64'(tdone[2] - tdone[1]), 64'd10);
    end
    @(negedge clk); @(negedge clk);
    chk("b2b_idle", 64'(busy8), 64'd0);

    run_rand(1, 400);
    run_rand(8, 300);
    run_rand(32, 300);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits; legal range 1 to 32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result of the last completed addition.
REQ-011 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL be a bit-serial full adder: one single-bit full-add per clock, LSB first, using one carry flop.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE, start=1 at an edge: capture a, b and cin into the carry flop; clear the bit counter; go to RUN.
REQ-015 IDLE, start=0: remain in IDLE; all registers hold.
REQ-016 Each RUN edge SHALL do the following in one step:
- s = a_sh[0] ^ b_sh[0] ^ c.
- c = majority(a_sh[0], b_sh[0], c).
- Shift a_sh and b_sh right by 1.
- Shift the result register right, inserting s at the MSB.
- Increment the counter.
REQ-017 The edge that processes bit WIDTH-1 SHALL load sum from the result register (including the bit being inserted) and cout from the new carry, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency: if start is accepted at edge k, done is high during the cycle after edge k+WIDTH; sum and cout are valid from that same cycle.
REQ-020 sum and cout SHALL hold their values until the next completion; a new start SHALL NOT disturb them mid-operation.
REQ-021 start in RUN or DONE SHALL be ignored with no queuing; the next operation needs start in IDLE.
REQ-022 start held continuously high SHALL give back-to-back operations, each WIDTH+2 cycles apart.
REQ-023 a, b and cin changing after capture SHALL NOT affect the result in progress.
REQ-024 The result SHALL equal (a + b + cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of the full sum.
REQ-025 WIDTH=1: RUN SHALL last one cycle and the result SHALL be a single full-add.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for clk:
- Go to IDLE.
- Drive busy=0, done=0, sum=0, cout=0.
- Clear the carry flop, counter, shift registers and result register.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done pulse for it, and sum/cout read 0.
REQ-029 After rst_n rises, the first start accepted SHALL behave exactly as in REQ-014.

Verification
REQ-030 WIDTH=8, a=8'h3C, b=8'h0F, cin=0, start for one cycle -> busy for 9 cycles, done pulse 9 cycles after start edge, sum=8'h4B, cout=0.
REQ-031 WIDTH=8:
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0.
REQ-032 Start with a=8'h10, b=8'h20, then pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> that start is ignored; sum=8'h30, cout=0; busy unchanged.
REQ-033 Drop rst_n at RUN cycle 4 -> busy=0, sum=0, cout=0 immediately; no done pulse; the next start completes normally.
REQ-034 start held high with a=8'h01, b=8'h01, cin=0 -> done pulses every 10 cycles; sum=8'h02 each time.
REQ-035 Random regression, 1000 operands at WIDTH in {1, 8, 32} -> {cout, sum} equals a+b+cin on every done pulse; done is never high for two consecutive cycles.
